// File: rtl/issue_ctrl.sv
// Issue/hazard controller sitting between decode and EX.
// Tracks in-flight register writes in a per-register scoreboard and serialises
// control-flow and memory instructions with a small FSM.
module issue_ctrl #(
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned CNT_W   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_in,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic [1:0]        id_mem_stage_state,
    input  logic [1:0]        id_wb_stage_state,
    input  logic              id_special_pc_flag,
    input  logic              ex_br_resolved,
    input  logic              ex_br_taken,
    input  logic              mem_done,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    output logic              issue_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic [1:0]        state_o,
    output logic              sb_err_o
);

    localparam logic [1:0]       MemNone = 2'b00;
    localparam logic [1:0]       WbNone  = 2'b00;
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StBrWait  = 2'b01,
        StMemWait = 2'b10,
        StFlush   = 2'b11
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q [REG_NUM];
    logic [CNT_W-1:0] cnt_d [REG_NUM];
    logic             sb_err_q, sb_err_d;
    logic             writes_rd;
    logic             hazard;
    logic             inc, dec;
    logic             inc_hit, dec_hit;

    assign writes_rd = (id_wb_stage_state != WbNone) && (id_rd != '0);

    // RAW hazard on any live source, or WAW when the destination counter is saturated
    always_comb begin
        hazard = 1'b0;
        if (id_use_rs1 && (id_rs1 != '0) && (cnt_q[id_rs1] != '0)) hazard = 1'b1;
        if (id_use_rs2 && (id_rs2 != '0) && (cnt_q[id_rs2] != '0)) hazard = 1'b1;
        if (writes_rd && (cnt_q[id_rd] == CntMax)) hazard = 1'b1;
    end

    // Issue/stall decisions are combinational; forced low while reset is held
    always_comb begin
        issue_o = !rst && rdy_in && id_valid && (state_q == StRun) && !hazard;
        stall_o = !rst && rdy_in && id_valid && !issue_o && (state_q != StFlush);
    end

    assign flush_o  = (state_q == StFlush);
    assign state_o  = state_q;
    assign sb_err_o = sb_err_q;

    assign inc = issue_o && writes_rd;
    assign dec = wb_valid && (wb_rd != '0);

    // Scoreboard next state: simultaneous inc/dec on one register cancel out
    always_comb begin
        sb_err_d = sb_err_q;
        inc_hit  = 1'b0;
        dec_hit  = 1'b0;
        for (int unsigned i = 0; i < REG_NUM; i++) begin
            cnt_d[i] = cnt_q[i];
            inc_hit  = inc && (id_rd == ADDR_W'(i));
            dec_hit  = dec && (wb_rd == ADDR_W'(i));
            if (inc_hit && !dec_hit) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec_hit && !inc_hit) begin
                if (cnt_q[i] == '0) begin
                    sb_err_d = 1'b1;  // retire without a matching issue
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // FSM, scoreboard and sticky error; rdy_in low freezes everything
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            cnt_q    <= '{default: '0};
            sb_err_q <= 1'b0;
        end else if (rdy_in) begin
            cnt_q    <= cnt_d;
            sb_err_q <= sb_err_d;
            unique case (state_q)
                StRun: begin
                    if (issue_o && id_special_pc_flag) begin
                        state_q <= StBrWait;
                    end else if (issue_o && (id_mem_stage_state != MemNone)) begin
                        state_q <= StMemWait;
                    end
                end
                StBrWait: begin
                    if (ex_br_resolved) begin
                        state_q <= ex_br_taken ? StFlush : StRun;
                    end
                end
                StMemWait: begin
                    if (mem_done) state_q <= StRun;
                end
                StFlush: state_q <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: reset, RAW stall, branch flush, memory wait,
// WAW saturation, sticky scoreboard error and rdy_in freeze.
module tb_issue_ctrl;

    localparam logic [1:0] NONE = 2'b00;
    localparam logic [1:0] RD   = 2'b01;
    localparam logic [1:0] M2R  = 2'b10;
    localparam logic [1:0] ARI  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdy_in;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
    logic       id_use_rs1, id_use_rs2;
    logic [1:0] id_mem_stage_state, id_wb_stage_state;
    logic       id_special_pc_flag;
    logic       ex_br_resolved, ex_br_taken, mem_done, wb_valid;
    logic       issue_o, stall_o, flush_o, sb_err_o;
    logic [1:0] state_o;

    int vectors;
    int miscompares;

    always #5 clk = ~clk;

    issue_ctrl #(
        .REG_NUM(32),
        .ADDR_W (5),
        .CNT_W  (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rdy_in            (rdy_in),
        .id_valid          (id_valid),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_use_rs1        (id_use_rs1),
        .id_use_rs2        (id_use_rs2),
        .id_rd             (id_rd),
        .id_mem_stage_state(id_mem_stage_state),
        .id_wb_stage_state (id_wb_stage_state),
        .id_special_pc_flag(id_special_pc_flag),
        .ex_br_resolved    (ex_br_resolved),
        .ex_br_taken       (ex_br_taken),
        .mem_done          (mem_done),
        .wb_valid          (wb_valid),
        .wb_rd             (wb_rd),
        .issue_o           (issue_o),
        .stall_o           (stall_o),
        .flush_o           (flush_o),
        .state_o           (state_o),
        .sb_err_o          (sb_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 0;
        id_mem_stage_state = NONE; id_wb_stage_state = NONE; id_special_pc_flag = 0;
        ex_br_resolved = 0; ex_br_taken = 0; mem_done = 0; wb_valid = 0; wb_rd = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic [1:0] mem,
                         input logic [1:0] wb, input logic spc);
        id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd; id_mem_stage_state = mem; id_wb_stage_state = wb; id_special_pc_flag = spc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 0; rdy_in = 1; clr();

        // Reset asserted with a valid instruction presented
        #1 rst = 1;
        instr(5, 1, 0, 0, 6, NONE, ARI, 0);
        #1;
        chk("rst_issue", issue_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_state", state_o, 0);
        chk("rst_sberr", sb_err_o, 0);
        tick(); tick();
        rst = 0; clr();

        // Build cnt[5]=2 and enter BR_WAIT, then reset mid-operation
        instr(0, 0, 0, 0, 5, NONE, ARI, 0);
        #1 chk("pre_addi5_a", issue_o, 1); tick();
        #1 chk("pre_addi5_b", issue_o, 1); tick();
        instr(1, 1, 2, 1, 0, NONE, NONE, 1);
        #1 chk("pre_beq_issue", issue_o, 1); tick();
        instr(5, 1, 1, 1, 6, NONE, ARI, 0);
        #1 chk("pre_state_br", state_o, 1);
        chk("pre_br_stall", stall_o, 1);
        rst = 1;
        #1 chk("rstmid_state", state_o, 0);
        chk("rstmid_issue", issue_o, 0);
        chk("rstmid_stall", stall_o, 0);
        chk("rstmid_flush", flush_o, 0);
        tick();
        rst = 0;
        #1 chk("rstmid_cnt5_clear", issue_o, 1);  // reads x5: counter must be 0
        tick();

        // RAW stall until x5 retires; retire cycle itself still stalls
        instr(0, 0, 0, 0, 5, NONE, ARI, 0);
        #1 chk("t2_addi5_issue", issue_o, 1); tick();
        instr(5, 1, 1, 1, 7, NONE, ARI, 0);
        #1 chk("t2_raw_stall", stall_o, 1);
        chk("t2_raw_noissue", issue_o, 0); tick();
        #1 chk("t2_raw_stall2", stall_o, 1);
        wb_valid = 1; wb_rd = 5;
        #1 chk("t2_no_bypass", stall_o, 1); tick();
        wb_valid = 0;
        #1 chk("t2_issue_after_wb", issue_o, 1); tick();

        // Taken branch: BR_WAIT -> FLUSH (one cycle) -> RUN
        instr(1, 1, 2, 1, 0, NONE, NONE, 1);
        #1 chk("t3_beq_issue", issue_o, 1); tick();
        instr(0, 0, 0, 0, 8, NONE, ARI, 0);
        #1 chk("t3_state_br", state_o, 1);
        chk("t3_stall", stall_o, 1); tick();
        ex_br_resolved = 1; ex_br_taken = 1;
        #1 chk("t3_stall_resolve", stall_o, 1); tick();
        ex_br_resolved = 0; ex_br_taken = 0;
        #1 chk("t3_flush", flush_o, 1);
        chk("t3_state_flush", state_o, 3);
        chk("t3_flush_nostall", stall_o, 0);
        chk("t3_flush_noissue", issue_o, 0); tick();
        #1 chk("t3_flush_gone", flush_o, 0);
        chk("t3_state_run", state_o, 0);
        chk("t3_refetch_issue", issue_o, 1); tick();

        // Not-taken branch returns straight to RUN without flush
        instr(1, 1, 2, 1, 0, NONE, NONE, 1);
        #1 chk("t3n_beq_issue", issue_o, 1); tick();
        clr(); ex_br_resolved = 1; tick();
        ex_br_resolved = 0;
        #1 chk("t3n_state_run", state_o, 0);
        chk("t3n_no_flush", flush_o, 0);

        // Load: MEM_WAIT until mem_done; stray pulses in RUN ignored
        instr(2, 1, 0, 0, 7, RD, M2R, 0);
        #1 chk("t4_lw_issue", issue_o, 1); tick();
        clr(); repeat (3) tick();
        #1 chk("t4_mem_wait", state_o, 2);
        mem_done = 1;
        #1 chk("t4_mem_wait_done", state_o, 2); tick();
        mem_done = 0;
        #1 chk("t4_back_run", state_o, 0);
        mem_done = 1; ex_br_resolved = 1; ex_br_taken = 1; tick();
        clr();
        #1 chk("t4_stray_state", state_o, 0);
        chk("t4_stray_flush", flush_o, 0);

        // WAW saturation on x9 and same-cycle issue+retire
        instr(0, 0, 0, 0, 9, NONE, ARI, 0);
        repeat (3) begin
            #1 chk("t5_fill", issue_o, 1); tick();
        end
        #1 chk("t5_waw_stall", stall_o, 1);
        chk("t5_waw_noissue", issue_o, 0);
        wb_valid = 1; wb_rd = 9;
        #1 chk("t5_waw_no_bypass", issue_o, 0); tick();
        #1 chk("t5_issue_retire", issue_o, 1); tick();
        wb_valid = 0;
        #1 chk("t5_issue_third", issue_o, 1); tick();
        #1 chk("t5_full_again", stall_o, 1);
        clr(); wb_valid = 1; wb_rd = 9; repeat (2) tick();
        instr(9, 1, 0, 0, 0, NONE, NONE, 0);
        #1 chk("t5_one_left", stall_o, 1); tick();
        wb_valid = 0;
        #1 chk("t5_drained", issue_o, 1); tick();
        clr();

        // x0 retire ignored; retire at count 0 sets sticky error
        wb_valid = 1; wb_rd = 0; tick();
        #1 chk("t6_x0_no_err", sb_err_o, 0);
        wb_rd = 4; tick();
        wb_valid = 0;
        #1 chk("t6_err_set", sb_err_o, 1); tick();
        #1 chk("t6_err_sticky", sb_err_o, 1);

        // rdy_in=0 freezes state and gates issue/stall; flush_o still follows state
        instr(1, 1, 2, 1, 0, NONE, NONE, 1);
        #1 chk("t6_beq_issue", issue_o, 1); tick();
        instr(0, 0, 0, 0, 11, NONE, ARI, 0);
        rdy_in = 0; ex_br_resolved = 1; ex_br_taken = 1;
        #1 chk("t6_rdy0_issue", issue_o, 0);
        chk("t6_rdy0_stall", stall_o, 0); tick();
        #1 chk("t6_frozen_br", state_o, 1);
        rdy_in = 1; tick();
        #1 chk("t6_state_flush", state_o, 3);
        rdy_in = 0;
        #1 chk("t6_flush_rdy0", flush_o, 1); tick();
        #1 chk("t6_frozen_flush", state_o, 3);
        rdy_in = 1; ex_br_resolved = 0; ex_br_taken = 0; tick();
        #1 chk("t6_run_again", state_o, 0);

        // Reset clears the sticky error
        rst = 1;
        #1 chk("final_rst_err", sb_err_o, 0);
        tick();
        rst = 0; clr();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
